// File: rtl/mp4_tag_lookup.sv
// ---------------------------------------------------------------------------
// mp4_tag_lookup
//
// Tag lookup controller for a direct-mapped cache whose tags live in an
// external single-port SRAM with one cycle of read latency. A request is
// accepted in IDLE. The SRAM read is issued in that same cycle, and the
// compare happens in the next cycle (LOOKUP). A miss raises miss_req until
// the memory side pulses fill_done. The new tag is then written in WRITE.
// Per-set valid bits are kept in flops because the SRAM powers up with
// undefined contents.
//
// Optional feature: define TAG_FLUSH_EN to add the 'flush' input. Flush high
// in IDLE clears every valid bit in one cycle and blocks acceptance.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   flush            (TAG_FLUSH_EN only) invalidate all sets while idle
//   req_valid/ready  lookup request handshake, req_addr = byte address
//                    (tag = [31:10], set = [9:5], offset ignored)
//   resp_valid       one-cycle lookup result, with resp_hit / resp_set
//   miss_req         refill request, miss_tag held until fill_done
//   fill_done        refill-complete pulse, only honoured while missing
//   tag_csb0/web0    SRAM chip select / write enable (active low)
//   tag_addr0        SRAM address, tag_din0 write data, tag_dout0 read data
// ---------------------------------------------------------------------------
module mp4_tag_lookup #(
    parameter int TAG_W = 22,
    parameter int SET_W = 5
) (
    input  logic             clk,
    input  logic             rst,
`ifdef TAG_FLUSH_EN
    input  logic             flush,
`endif
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_addr,
    output logic             resp_valid,
    output logic             resp_hit,
    output logic [SET_W-1:0] resp_set,
    output logic             miss_req,
    output logic [TAG_W-1:0] miss_tag,
    input  logic             fill_done,
    output logic             tag_csb0,
    output logic             tag_web0,
    output logic [SET_W-1:0] tag_addr0,
    output logic [TAG_W-1:0] tag_din0,
    input  logic [TAG_W-1:0] tag_dout0
);

    localparam int NUM_SETS = 1 << SET_W;
    localparam int SET_LSB  = 5;
    localparam int TAG_LSB  = SET_LSB + SET_W;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_MISS,
        ST_WRITE
    } state_t;

    state_t                state_reg;
    logic [TAG_W-1:0]      tag_reg;
    logic [SET_W-1:0]      set_reg;
    logic [NUM_SETS-1:0]   valid_bits;

    logic                  flush_now;
    logic                  accept;
    logic                  clear_all;
    logic                  lookup_hit;
    logic                  addr_unused;

`ifdef TAG_FLUSH_EN
    assign flush_now = flush;
`else
    assign flush_now = 1'b0;
`endif

    // Byte offset bits never take part in the lookup.
    assign addr_unused = ^req_addr[SET_LSB-1:0];

    // A flush cycle takes priority over a request arriving in the same cycle.
    assign accept     = (state_reg == ST_IDLE) && !rst && !flush_now && req_valid;
    assign clear_all  = (state_reg == ST_IDLE) && flush_now;
    // An entry never written since reset/flush misses even if the SRAM
    // happens to hold a matching pattern.
    assign lookup_hit = valid_bits[set_reg] && (tag_dout0 == tag_reg);

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            tag_reg   <= '0;
            set_reg   <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        tag_reg   <= req_addr[TAG_LSB +: TAG_W];
                        set_reg   <= req_addr[SET_LSB +: SET_W];
                        state_reg <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: state_reg <= lookup_hit ? ST_IDLE : ST_MISS;
                ST_MISS: begin
                    if (fill_done) begin
                        state_reg <= ST_WRITE;
                    end
                end
                ST_WRITE: state_reg <= ST_IDLE;
                default:  state_reg <= ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Per-set valid bits: cleared by reset or idle flush, set on refill
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NUM_SETS; gi++) begin : g_valid
            logic valid_reg;
            always_ff @(posedge clk) begin
                if (rst || clear_all) begin
                    valid_reg <= 1'b0;
                end else if (state_reg == ST_WRITE && set_reg == SET_W'(gi)) begin
                    valid_reg <= 1'b1;
                end
            end
            assign valid_bits[gi] = valid_reg;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Output decode. Outputs are held inactive while reset is asserted so
    // that nothing leaks out of a state that is being abandoned.
    // ------------------------------------------------------------------
    always_comb begin
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_hit   = 1'b0;
        resp_set   = '0;
        miss_req   = 1'b0;
        miss_tag   = '0;
        tag_csb0   = 1'b1;
        tag_web0   = 1'b1;
        tag_addr0  = '0;
        tag_din0   = '0;
        if (!rst) begin
            case (state_reg)
                ST_IDLE: begin
                    req_ready = !flush_now;
                    if (accept) begin
                        // Read issued in the accept cycle; data returns in LOOKUP.
                        tag_csb0  = 1'b0;
                        tag_addr0 = req_addr[SET_LSB +: SET_W];
                    end
                end
                ST_LOOKUP: begin
                    resp_valid = 1'b1;
                    resp_hit   = lookup_hit;
                    resp_set   = set_reg;
                end
                ST_MISS: begin
                    miss_req = 1'b1;
                    miss_tag = tag_reg;
                end
                ST_WRITE: begin
                    tag_csb0  = 1'b0;
                    tag_web0  = 1'b0;
                    tag_addr0 = set_reg;
                    tag_din0  = tag_reg;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/mp4_tag_lookup.md
MP4_TAG_LOOKUP -- requirements
Module: mp4_tag_lookup

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: clk (rising edge) and rst (synchronous, active-high).
REQ-002 Port list, one per line (name, direction, width, meaning):
- clk  in  1  clock
- rst  in  1  sync active-high reset
- req_valid  in  1  lookup request
- req_ready  out  1  block accepts request
- req_addr  in  32  byte address; tag=[31:10], set=[9:5], offset=[4:0] ignored
- resp_valid  out  1  lookup result valid
- resp_hit  out  1  tag matched a valid entry
- resp_set  out  5  set index of result
- miss_req  out  1  refill request to memory side
- miss_tag  out  22  tag being refilled
- fill_done  in  1  refill complete, single-cycle pulse
- tag_csb0  out  1  tag SRAM chip select, active low
- tag_web0  out  1  tag SRAM write enable, active low
- tag_addr0  out  5  tag SRAM address
- tag_din0  out  22  tag SRAM write data
- tag_dout0  in  22  tag SRAM read data
REQ-003 Parameters, one per line (name, default, meaning): TAG_W, 22, tag width; SET_W, 5, set index width.

Function
REQ-004 SHALL implement FSM states IDLE, LOOKUP, MISS, WRITE.
REQ-005 IDLE: req_ready=1; on req_valid, SHALL latch tag and set, drive tag_csb0=0, tag_web0=1, tag_addr0=req_addr[9:5] in the same cycle (combinationally), and go to LOOKUP.
REQ-006 All other states: req_ready=0; requests are not accepted.
REQ-007 LOOKUP: SHALL sample tag_dout0 (tag SRAM read latency: one cycle); resp_valid=1; resp_set=latched set; resp_hit = valid[set] AND (tag_dout0 == latched tag).
REQ-008 LOOKUP hit -> IDLE. LOOKUP miss -> MISS. A hit responds exactly 1 cycle after acceptance; max throughput is one lookup per 2 cycles.
REQ-009 MISS: miss_req=1 and miss_tag=latched tag, held stable until fill_done; on fill_done -> WRITE. fill_done outside MISS SHALL be ignored.
REQ-010 WRITE (one cycle): tag_csb0=0, tag_web0=0, tag_addr0=latched set, tag_din0=latched tag; valid[set] set to 1; -> IDLE.
REQ-011 SHALL keep a 32-entry valid-bit register array internally, because tag SRAM contents are undefined after power-up; an invalid entry is always a miss, even when the tag matches.
REQ-012 When not in IDLE-accept, LOOKUP or WRITE: tag_csb0=1, tag_web0=1, tag_addr0=0, tag_din0=0.
REQ-013 resp_valid, resp_hit, miss_req SHALL be 0 outside their stated states; resp_set=0 and miss_tag=0 when their qualifiers are low.

Reset
REQ-014 rst SHALL return the FSM to IDLE and clear all valid bits on the next clk edge, from any state.
REQ-015 During and immediately after reset, all outputs SHALL be inactive: req_ready=1 after reset, tag_csb0=1, tag_web0=1, and all other outputs 0.
REQ-016 Reset in MISS SHALL abandon the refill: miss_req drops, and a later fill_done is ignored.

Configuration
REQ-017 Macro TAG_FLUSH_EN: when defined, adds input flush (1 bit); flush high in IDLE clears all valid bits in one cycle, and req_valid in that same cycle is not accepted (req_ready=0). Flush outside IDLE is ignored.
REQ-018 Without TAG_FLUSH_EN: no flush port; valid bits are cleared only by rst.

Verification
REQ-019 After rst, request 0x0000_0420 (set 1) -> LOOKUP gives resp_valid=1, resp_hit=0; miss_req=1 with miss_tag=0x000001.
REQ-020 Pulse fill_done after 5 cycles -> WRITE cycle shows tag_web0=0, tag_addr0=1, tag_din0=0x000001; then re-request 0x0000_0420 -> resp_hit=1 one cycle after acceptance.
REQ-021 Request 0x0000_0820 (set 1, tag 0x000002) after REQ-020 -> miss; fill replaces the tag, and 0x0000_0420 then misses.
REQ-022 rst asserted in MISS -> next cycle is IDLE, miss_req=0; a subsequent fill_done causes no SRAM write (tag_web0 stays 1).
REQ-023 Back-to-back req_valid held high with hits on sets 0..3 -> req_ready toggles 1/0 and four resp_valid pulses arrive on alternate cycles.
REQ-024 TAG_FLUSH_EN defined: fill set 2, assert flush in IDLE -> the next lookup of the same address gives resp_hit=0.
